gate_seq_ctrl: RTL and testbench
================================

Name: gate_seq_ctrl

Overview:
- UART-commanded gate sequencer for the N-phase bridge.
- Assembles a MSG_BYTES-byte frame from the uart_rx byte stream into a pulse-width word.
- On a rising edge of the external shoot input, runs one commutation sequence across N_PHASES complementary gate pairs with enforced dead time.
- Sits between uart_rx and the transistor gate pins, replacing the two-byte wait / MODULATE state logic in the top level.

Parameters:
- N_PHASES, 3, number of bridge legs; one high-side and one low-side gate per leg; legal 2..8.
- MSG_BYTES, 2, bytes per frame, MSB first; pulse width is MSG_BYTES*8 bits.
- DEAD_TIME, 4, all-gates-off clocks between steps; legal 1..255.
- BYTE_TIMEOUT, 48000, maximum clocks between bytes of one frame before the partial frame is dropped.

Ports:
- clk  in  1  system clock (48 MHz HFOSC).
- reset  in  1  asynchronous, active-low reset.
- data_received  in  8  byte from uart_rx.
- rx_done  in  1  one-cycle strobe; data_received and parity_error are valid.
- parity_error  in  1  parity flag for the current byte.
- shoot  in  1  asynchronous trigger input (gpio).
- err_clr  in  1  one-cycle pulse; leaves RX_ERROR.
- gate_hi  out  N_PHASES  high-side gate drives; 1 = transistor on.
- gate_lo  out  N_PHASES  low-side gate drives; 1 = transistor on.
- busy  out  1  sequence in progress.
- frame_valid  out  1  one-cycle pulse; a new width has been accepted.
- rx_err  out  1  latched reception error.
- timeout  out  1  one-cycle pulse; a partial frame was dropped.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0 immediately, including while a sequence is mid-flight; the gates must never glitch on.
  - Shadow width and active width go to 0; receive FSM enters WAIT_BYTE.
- Receive FSM states: WAIT_BYTE, ASSEMBLE, CHECK (CHECKSUM_EN only), RX_ERROR.
  - WAIT_BYTE:
    - rx_done with parity_error=0: store byte as MSB, byte_cnt=1, go to ASSEMBLE.
    - rx_done with parity_error=1: go to RX_ERROR.
    - If MSG_BYTES=1, the first byte completes the frame.
  - ASSEMBLE:
    - Each good byte shifts into the low end.
    - On byte MSG_BYTES: shadow_width <= frame and frame_valid pulses on the next clock; return to WAIT_BYTE.
    - Parity error: RX_ERROR.
    - Inter-byte counter reaching BYTE_TIMEOUT: drop partial frame, pulse timeout, return to WAIT_BYTE, rx_err unchanged.
  - RX_ERROR:
    - rx_err=1; all bytes are ignored.
    - err_clr moves to WAIT_BYTE and clears rx_err on the same edge.
    - Shadow width keeps its last good value.
- Sequencer FSM states: IDLE, ON, DEAD.
  - Shoot path: shoot passes through a 2-flop synchronizer; edge = sync=1 and previous=0.
  - Edge in IDLE with shadow_width != 0:
    - active_width <= shadow_width, step=0, busy=1, enter ON.
    - Gates change on the clock after edge detection, i.e. the 3rd clk edge after shoot rises.
  - Edge in IDLE with shadow_width = 0: ignored; busy stays 0.
  - ON, step s: gate_hi[s]=1, gate_lo[(s+1) mod N_PHASES]=1, all others 0; hold exactly active_width clocks.
  - DEAD: all gates 0 for exactly DEAD_TIME clocks.
    - Then step++ and enter ON.
    - After step N_PHASES-1: IDLE, busy=0 on the same edge that DEAD ends.
  - Shoot edges while busy are ignored; there is no queueing.
  - A frame completing mid-sequence updates shadow_width only; the running sequence keeps active_width.
  - gate_hi[k] and gate_lo[k] are never both 1; this holds by construction.
- Width rules:
  - Counters are unsigned, MSG_BYTES*8 bits.
  - active_width = 2^(8*MSG_BYTES)-1 is legal and must not wrap.
  - Total sequence length = N_PHASES*(active_width+DEAD_TIME) clocks.
- Simultaneous events:
  - rx_done and err_clr in the same cycle while in RX_ERROR: err_clr wins; the byte is discarded.
  - The receive and sequencer FSMs are independent.

Optional Feature:
- Macro: GATE_SEQ_CHECKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte equal to the XOR of the MSG_BYTES data bytes.
  - CHECK compares it; a mismatch goes to RX_ERROR and shadow_width is unchanged.
  - frame_valid pulses one clock after the checksum byte.
- Undefined: no trailing byte; the CHECK state is absent.

Decomposition:
- Shared header gate_seq.vh holds:
  - Receive and sequencer state encodings.
  - Default DEAD_TIME and BYTE_TIMEOUT constants.
  - The TR_ON / TR_OFF levels.
- One natural sub-module, frame_assembler:
  - Receive FSM, timeout counter and optional checksum.
  - Outputs shadow_width, frame_valid, rx_err and timeout.
- gate_seq_ctrl instantiates frame_assembler and contains the sequencer.

Test Plan (N_PHASES=3, MSG_BYTES=2, DEAD_TIME=4, BYTE_TIMEOUT=100):
- Frame: bytes 0x00, 0x05, then shoot pulse.
  - frame_valid pulses once.
  - gate_hi = 001/010/100 with gate_lo = 010/100/001, each for 5 clocks, separated by 4-clock all-zero gaps.
  - busy high for 27 clocks.
- Byte 0x12, then no byte for 100 clocks: timeout pulses; then 0x00, 0x03 plus shoot gives 3-clock steps.
- Second byte sent with parity_error=1: rx_err=1 and further frames are ignored.
  - err_clr clears rx_err.
  - Next frame 0x00, 0x02 is accepted.
- Shoot with width=0 after reset: no gate activity, busy stays 0.
  - Shoot pulse during a running sequence is ignored.
  - A frame received mid-sequence is used on the next shoot.
- Assert reset mid-ON: all gates 0 asynchronously within the same cycle; after release, shoot does nothing until a new frame arrives.
- GATE_SEQ_CHECKSUM_EN: bytes 0x01, 0x02, 0x03 are accepted (width 0x0102); bytes 0x01, 0x02, 0x07 set rx_err.

Source files
------------

// File: rtl/gate_seq_ctrl_pkg.sv
// Shared encodings, default timing constants and gate drive levels for gate_seq_ctrl.
// GATE_SEQ_CHECKSUM_EN adds the CHECK receive state for the trailing XOR byte.
package gate_seq_ctrl_pkg;

  localparam int DEFAULT_DEAD_TIME    = 4;
  localparam int DEFAULT_BYTE_TIMEOUT = 48000;

  localparam logic TR_ON  = 1'b1;
  localparam logic TR_OFF = 1'b0;

  typedef enum logic [1:0] {
    RX_WAIT_BYTE = 2'd0,
    RX_ASSEMBLE  = 2'd1,
`ifdef GATE_SEQ_CHECKSUM_EN
    RX_CHECK     = 2'd2,
`endif
    RX_ERROR     = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_ON   = 2'd1,
    SEQ_DEAD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gate_seq_ctrl_frame_assembler.sv
// Receive FSM: builds a MSB-first pulse-width word from uart_rx bytes, with inter-byte timeout.
// With GATE_SEQ_CHECKSUM_EN a trailing XOR byte must match before the width is accepted.
module frame_assembler
  import gate_seq_ctrl_pkg::*;
#(
  parameter int MSG_BYTES    = 2,
  parameter int BYTE_TIMEOUT = DEFAULT_BYTE_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_received,
  input  logic                   rx_done,
  input  logic                   parity_error,
  input  logic                   err_clr,
  output logic [MSG_BYTES*8-1:0] shadow_width,
  output logic                   frame_valid,
  output logic                   rx_err,
  output logic                   timeout
);

  localparam int W  = MSG_BYTES * 8;
  localparam int CW = $clog2(MSG_BYTES + 1);
  localparam int TW = $clog2(BYTE_TIMEOUT + 1);

  rx_state_e       state_q;
  logic [W-1:0]    shift_q;
  logic [CW-1:0]   byte_cnt_q;
  logic [TW-1:0]   timer_q;
  logic [W-1:0]    shadow_q;
  logic            frame_valid_q;
  logic            rx_err_q;
  logic            timeout_q;
`ifdef GATE_SEQ_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic [W-1:0] frame_d;
  logic         last_byte;
  logic         timer_expired;

  assign frame_d       = (shift_q << 8) | W'(data_received);
  assign last_byte     = (byte_cnt_q == CW'(MSG_BYTES - 1));
  assign timer_expired = (timer_q == TW'(BYTE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RX_WAIT_BYTE;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      timer_q       <= '0;
      shadow_q      <= '0;
      frame_valid_q <= 1'b0;
      rx_err_q      <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef GATE_SEQ_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      frame_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      case (state_q)
        RX_WAIT_BYTE: begin
          timer_q <= '0;
          if (rx_done && parity_error) begin
            state_q  <= RX_ERROR;
            rx_err_q <= 1'b1;
          end else if (rx_done) begin
            shift_q    <= W'(data_received);
            byte_cnt_q <= CW'(1);
`ifdef GATE_SEQ_CHECKSUM_EN
            csum_q     <= data_received;
            state_q    <= (MSG_BYTES == 1) ? RX_CHECK : RX_ASSEMBLE;
`else
            if (MSG_BYTES == 1) begin
              shadow_q      <= W'(data_received);
              frame_valid_q <= 1'b1;
            end else begin
              state_q <= RX_ASSEMBLE;
            end
`endif
          end
        end

        RX_ASSEMBLE: begin
          if (rx_done && parity_error) begin
            state_q  <= RX_ERROR;
            rx_err_q <= 1'b1;
          end else if (rx_done) begin
            shift_q    <= frame_d;
            byte_cnt_q <= byte_cnt_q + CW'(1);
            timer_q    <= '0;
`ifdef GATE_SEQ_CHECKSUM_EN
            csum_q     <= csum_q ^ data_received;
            if (last_byte) state_q <= RX_CHECK;
`else
            if (last_byte) begin
              shadow_q      <= frame_d;
              frame_valid_q <= 1'b1;
              state_q       <= RX_WAIT_BYTE;
            end
`endif
          end else if (timer_expired) begin
            state_q   <= RX_WAIT_BYTE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end

`ifdef GATE_SEQ_CHECKSUM_EN
        // The assembled word waits in shift_q until its checksum byte arrives.
        RX_CHECK: begin
          if (rx_done && parity_error) begin
            state_q  <= RX_ERROR;
            rx_err_q <= 1'b1;
          end else if (rx_done) begin
            if (data_received == csum_q) begin
              shadow_q      <= shift_q;
              frame_valid_q <= 1'b1;
              state_q       <= RX_WAIT_BYTE;
            end else begin
              state_q  <= RX_ERROR;
              rx_err_q <= 1'b1;
            end
          end else if (timer_expired) begin
            state_q   <= RX_WAIT_BYTE;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
`endif

        RX_ERROR: begin
          if (err_clr) begin
            state_q  <= RX_WAIT_BYTE;
            rx_err_q <= 1'b0;
          end
        end

        default: state_q <= RX_WAIT_BYTE;
      endcase
    end
  end

  assign shadow_width = shadow_q;
  assign frame_valid  = frame_valid_q;
  assign rx_err       = rx_err_q;
  assign timeout      = timeout_q;

endmodule

// File: rtl/gate_seq_ctrl.sv
// UART-commanded N-phase gate sequencer: frame_assembler supplies the width, shoot runs one sequence.
// Build with GATE_SEQ_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module gate_seq_ctrl
  import gate_seq_ctrl_pkg::*;
#(
  parameter int N_PHASES     = 3,
  parameter int MSG_BYTES    = 2,
  parameter int DEAD_TIME    = DEFAULT_DEAD_TIME,
  parameter int BYTE_TIMEOUT = DEFAULT_BYTE_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data_received,
  input  logic                rx_done,
  input  logic                parity_error,
  input  logic                shoot,
  input  logic                err_clr,
  output logic [N_PHASES-1:0] gate_hi,
  output logic [N_PHASES-1:0] gate_lo,
  output logic                busy,
  output logic                frame_valid,
  output logic                rx_err,
  output logic                timeout
);

  localparam int W  = MSG_BYTES * 8;
  localparam int SW = $clog2(N_PHASES);

  logic [W-1:0] shadow_width;

  frame_assembler #(
    .MSG_BYTES    (MSG_BYTES),
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_frame_assembler (
    .clk           (clk),
    .reset         (reset),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .err_clr       (err_clr),
    .shadow_width  (shadow_width),
    .frame_valid   (frame_valid),
    .rx_err        (rx_err),
    .timeout       (timeout)
  );

  logic shoot_meta_q;
  logic shoot_sync_q;
  logic shoot_prev_q;
  logic shoot_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shoot_meta_q <= 1'b0;
      shoot_sync_q <= 1'b0;
      shoot_prev_q <= 1'b0;
    end else begin
      shoot_meta_q <= shoot;
      shoot_sync_q <= shoot_meta_q;
      shoot_prev_q <= shoot_sync_q;
    end
  end

  assign shoot_edge = shoot_sync_q & ~shoot_prev_q;

  function automatic logic [SW-1:0] next_step(input logic [SW-1:0] s);
    return (s == SW'(N_PHASES - 1)) ? '0 : s + SW'(1);
  endfunction

  function automatic logic [N_PHASES-1:0] leg_mask(input logic [SW-1:0] s);
    logic [N_PHASES-1:0] pat;
    pat    = {N_PHASES{TR_OFF}};
    pat[s] = TR_ON;
    return pat;
  endfunction

  seq_state_e          seq_q;
  logic [SW-1:0]       step_q;
  logic [W-1:0]        active_q;
  logic [W-1:0]        on_cnt_q;
  logic [7:0]          dead_cnt_q;
  logic [N_PHASES-1:0] gate_hi_q;
  logic [N_PHASES-1:0] gate_lo_q;
  logic                busy_q;

  // Gates are only ever loaded from leg_mask pairs (s, s+1), so a leg's high and low
  // sides can never be on together; the ON counter stops at width-1 so full-scale never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q      <= SEQ_IDLE;
      step_q     <= '0;
      active_q   <= '0;
      on_cnt_q   <= '0;
      dead_cnt_q <= '0;
      gate_hi_q  <= {N_PHASES{TR_OFF}};
      gate_lo_q  <= {N_PHASES{TR_OFF}};
      busy_q     <= 1'b0;
    end else begin
      case (seq_q)
        SEQ_IDLE: begin
          if (shoot_edge && (shadow_width != '0)) begin
            active_q  <= shadow_width;
            step_q    <= '0;
            on_cnt_q  <= '0;
            busy_q    <= 1'b1;
            gate_hi_q <= leg_mask('0);
            gate_lo_q <= leg_mask(next_step('0));
            seq_q     <= SEQ_ON;
          end
        end

        SEQ_ON: begin
          if (on_cnt_q == active_q - W'(1)) begin
            gate_hi_q  <= {N_PHASES{TR_OFF}};
            gate_lo_q  <= {N_PHASES{TR_OFF}};
            dead_cnt_q <= '0;
            seq_q      <= SEQ_DEAD;
          end else begin
            on_cnt_q <= on_cnt_q + W'(1);
          end
        end

        SEQ_DEAD: begin
          if (dead_cnt_q == 8'(DEAD_TIME - 1)) begin
            if (step_q == SW'(N_PHASES - 1)) begin
              busy_q <= 1'b0;
              seq_q  <= SEQ_IDLE;
            end else begin
              step_q    <= next_step(step_q);
              on_cnt_q  <= '0;
              gate_hi_q <= leg_mask(next_step(step_q));
              gate_lo_q <= leg_mask(next_step(next_step(step_q)));
              seq_q     <= SEQ_ON;
            end
          end else begin
            dead_cnt_q <= dead_cnt_q + 8'd1;
          end
        end

        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign gate_hi = gate_hi_q;
  assign gate_lo = gate_lo_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl: frame vector table plus hand-written timing sequences.
// Builds with or without GATE_SEQ_CHECKSUM_EN; frames get their XOR byte appended when defined.
`timescale 1ns/1ps
module tb_gate_seq_ctrl;

  localparam int N  = 3;
  localparam int MB = 2;
  localparam int DT = 4;
  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   data_received = 8'h00;
  logic         rx_done = 1'b0;
  logic         parity_error = 1'b0;
  logic         shoot = 1'b0;
  logic         err_clr = 1'b0;
  logic [N-1:0] gate_hi;
  logic [N-1:0] gate_lo;
  logic         busy;
  logic         frame_valid;
  logic         rx_err;
  logic         timeout;

  int errors = 0;
  int checks = 0;
  int toCount = 0;

  typedef struct packed {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
  } gate_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       par1;
    logic       expValid;
    logic       expErr;
    int         width;
  } vec_t;

  gate_t seqQ[$];
  int    fvQ[$];
  vec_t  vecs[6];

  gate_seq_ctrl #(
    .N_PHASES     (N),
    .MSG_BYTES    (MB),
    .DEAD_TIME    (DT),
    .BYTE_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .shoot         (shoot),
    .err_clr       (err_clr),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .busy          (busy),
    .frame_valid   (frame_valid),
    .rx_err        (rx_err),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every busy or gate-active cycle consumes one expected gate record.
  always @(negedge clk) begin
    if (reset) begin
      if (busy || gate_hi != '0 || gate_lo != '0) begin
        if (seqQ.size() == 0) begin
          checkOutput("unexpected_gate_activity", {gate_hi, gate_lo, busy}, 64'd0);
        end else begin
          checkOutput("gate_sequence", {gate_hi, gate_lo, busy}, seqQ.pop_front());
          checkOutput("gate_overlap", gate_hi & gate_lo, 64'd0);
        end
      end
      if (frame_valid) begin
        checkOutput("frame_valid_expected", fvQ.size() != 0, 64'd1);
        if (fvQ.size() != 0) void'(fvQ.pop_front());
      end
      if (timeout) toCount++;
    end
  end

  task automatic pushSequence(input int width);
    for (int s = 0; s < N; s++) begin
      gate_t e;
      e.hi   = N'(1) << s;
      e.lo   = N'(1) << ((s + 1) % N);
      e.busy = 1'b1;
      for (int c = 0; c < width; c++) seqQ.push_back(e);
      e = '0;
      e.busy = 1'b1;
      for (int c = 0; c < DT; c++) seqQ.push_back(e);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic par);
    @(posedge clk); #1;
    data_received = b;
    parity_error  = par;
    rx_done       = 1'b1;
    @(posedge clk); #1;
    rx_done      = 1'b0;
    parity_error = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b0, input logic [7:0] b1, input logic par1);
    sendByte(b0, 1'b0);
    sendByte(b1, par1);
`ifdef GATE_SEQ_CHECKSUM_EN
    sendByte(b0 ^ b1, 1'b0);
`endif
  endtask

  // Gates must still be idle after the 2nd edge and active after the 3rd edge past shoot rising.
  task automatic startShoot(input int width);
    @(posedge clk); #1;
    if (width != 0) pushSequence(width);
    shoot = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("shoot_latency_early", busy, 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("shoot_latency_start", busy, (width != 0) ? 64'd1 : 64'd0);
    shoot = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    while (seqQ.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("sequence_complete", seqQ.size(), 64'd0);
    seqQ.delete();
    repeat (6) @(negedge clk);
    checkOutput("idle_after_sequence", {busy, gate_hi, gate_lo}, 64'd0);
  endtask

  task automatic pulseErrClrWithByte(input logic [7:0] b);
    @(posedge clk); #1;
    err_clr       = 1'b1;
    rx_done       = 1'b1;
    data_received = b;
    @(posedge clk); #1;
    err_clr = 1'b0;
    rx_done = 1'b0;
    @(negedge clk);
    checkOutput("err_clr_clears", rx_err, 64'd0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    if (v.expValid) fvQ.push_back(v.width);
    sendFrame(v.b0, v.b1, v.par1);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("vec%0d_frame_valid", idx), fvQ.size(), 64'd0);
    checkOutput($sformatf("vec%0d_rx_err", idx), rx_err, v.expErr);
    startShoot(v.width);
    waitDone();
    if (v.expErr) begin
      sendFrame(8'h00, 8'h07, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput($sformatf("vec%0d_err_sticky", idx), rx_err, 64'd1);
      pulseErrClrWithByte(8'h55);
    end
  endtask

  initial begin : watchdog
    #3ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int toBefore;

    vecs[0] = '{8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 5};
    vecs[1] = '{8'h00, 8'h03, 1'b0, 1'b1, 1'b0, 3};
    vecs[2] = '{8'h00, 8'h02, 1'b1, 1'b0, 1'b1, 3};
    vecs[3] = '{8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 2};
    vecs[4] = '{8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 256};
    vecs[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 1'b0, 1};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {gate_hi, gate_lo, busy, frame_valid, rx_err, timeout}, 64'd0);
    #2 reset = 1'b1;

    $display("[TB] shoot with zero width after reset");
    startShoot(0);
    waitDone();

    $display("[TB] frame vector table");
    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    $display("[TB] inter-byte timeout");
    toBefore = toCount;
    sendByte(8'h12, 1'b0);
    repeat (90) @(negedge clk);
    checkOutput("no_early_timeout", toCount - toBefore, 64'd0);
    repeat (20) @(negedge clk);
    checkOutput("timeout_pulse", toCount - toBefore, 64'd1);
    checkOutput("timeout_keeps_rx_err", rx_err, 64'd0);
    fvQ.push_back(3);
    sendFrame(8'h00, 8'h03, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("frame_after_timeout", fvQ.size(), 64'd0);
    startShoot(3);
    waitDone();

    $display("[TB] shoot and frame during a running sequence");
    fvQ.push_back(5);
    sendFrame(8'h00, 8'h05, 1'b0);
    startShoot(5);
    repeat (4) @(negedge clk);
    shoot = 1'b1;
    repeat (3) @(posedge clk);
    #1 shoot = 1'b0;
    fvQ.push_back(4);
    sendFrame(8'h00, 8'h04, 1'b0);
    waitDone();
    checkOutput("mid_sequence_frame", fvQ.size(), 64'd0);
    startShoot(4);
    waitDone();

    $display("[TB] asynchronous reset during ON");
    startShoot(4);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset_gates", {busy, gate_hi, gate_lo}, 64'd0);
    seqQ.delete();
    fvQ.delete();
    repeat (2) @(negedge clk);
    checkOutput("reset_rx_err", rx_err, 64'd0);
    #2 reset = 1'b1;
    startShoot(0);
    waitDone();
    fvQ.push_back(2);
    sendFrame(8'h00, 8'h02, 1'b0);
    startShoot(2);
    waitDone();

`ifdef GATE_SEQ_CHECKSUM_EN
    $display("[TB] checksum frames");
    fvQ.push_back(258);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("checksum_good_frame", fvQ.size(), 64'd0);
    checkOutput("checksum_good_rx_err", rx_err, 64'd0);
    startShoot(258);
    waitDone();
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h07, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("checksum_bad_rx_err", rx_err, 64'd1);
    startShoot(258);
    waitDone();
    pulseErrClrWithByte(8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
